// File: rtl/mux_9to1.sv
// Registered 9-to-1 word multiplexer.
// A 4-bit select code picks one of nine operands. The chosen word is
// registered with one cycle of latency. Codes 9..15 are out of range: they
// register FILL_VAL and raise sel_err instead of y_valid.
module mux_9to1 #(
  parameter int              DATA_W   = 16,
  parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              sel_err
);

  logic [DATA_W-1:0] y_next;
  logic              in_range;

  // Parallel decode of the select code; each code maps to exactly one source.
  always_comb begin
    y_next   = FILL_VAL;
    in_range = 1'b1;
    unique case (sel)
      4'd0:    y_next = a;
      4'd1:    y_next = b;
      4'd2:    y_next = c;
      4'd3:    y_next = d;
      4'd4:    y_next = e;
      4'd5:    y_next = f;
      4'd6:    y_next = g;
      4'd7:    y_next = h;
      4'd8:    y_next = i;
      default: begin
        y_next   = FILL_VAL;
        in_range = 1'b0;
      end
    endcase
  end

  // Output register: reset wins over enable; with en low everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      sel_err <= 1'b0;
    end else if (en) begin
      y       <= y_next;
      y_valid <= in_range;
      sel_err <= ~in_range;
    end
  end

endmodule

// File: tb/tb_mux_9to1.sv
// Self-checking bench for mux_9to1: directed plan followed by random traffic,
// all checked against a behavioural model of the selection rules.
module tb_mux_9to1;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] FILL = '0;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [3:0]        sel;
  logic [DATA_W-1:0] ops [9];
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              sel_err;

  logic [DATA_W-1:0] exp_y;
  logic              exp_v;
  logic              exp_e;

  int n_assert = 0;
  int n_fail   = 0;
  int n_step   = 0;

  always #5 clk = ~clk;

  mux_9to1 #(.DATA_W(DATA_W), .FILL_VAL(FILL)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .a(ops[0]), .b(ops[1]), .c(ops[2]), .d(ops[3]), .e(ops[4]),
    .f(ops[5]), .g(ops[6]), .h(ops[7]), .i(ops[8]),
    .y(y), .y_valid(y_valid), .sel_err(sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, n_step, obs, expv);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic r, input logic en_i, input logic [3:0] s);
    rst = r;
    en  = en_i;
    sel = s;
    if (r) begin
      exp_y = '0; exp_v = 1'b0; exp_e = 1'b0;
    end else if (en_i) begin
      if (int'(s) < 9) begin
        exp_y = ops[int'(s)]; exp_v = 1'b1; exp_e = 1'b0;
      end else begin
        exp_y = FILL; exp_v = 1'b0; exp_e = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    n_step++;
    chk("y",       32'(y),             32'(exp_y));
    chk("y_valid", 32'(y_valid),       32'(exp_v));
    chk("sel_err", 32'(sel_err),       32'(exp_e));
    chk("excl",    32'(y_valid & sel_err), 32'd0);
  endtask

  task automatic load_plan_data();
    ops[0] = 16'h1234; ops[1] = 16'h5678; ops[2] = 16'h9101;
    ops[3] = 16'h1213; ops[4] = 16'h9873; ops[5] = 16'hfefd;
    ops[6] = 16'h1ddd; ops[7] = 16'hbcde; ops[8] = 16'hefdd;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 4'd0;
    for (int k = 0; k < 9; k++) ops[k] = 16'(k * 16'h1111 + 16'h0f0f);
    exp_y = '0; exp_v = 1'b0; exp_e = 1'b0;

    // Reset with arbitrary inputs, then release with en low.
    step(1'b1, 1'b1, 4'd2);
    step(1'b1, 1'b1, 4'd12);
    step(1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b0, 4'd9);

    // Full in-range sweep, back to back.
    load_plan_data();
    for (int s = 0; s < 9; s++) step(1'b0, 1'b1, 4'(s));

    // Out-of-range sweep, then recovery.
    for (int s = 9; s < 16; s++) step(1'b0, 1'b1, 4'(s));
    step(1'b0, 1'b1, 4'd3);

    // Hold: inputs move but en is low.
    step(1'b0, 1'b1, 4'd1);
    ops[1] = 16'haaaa;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'd7);
    step(1'b0, 1'b1, 4'd7);

    // Data tracking on a constant select; unselected inputs must not matter.
    load_plan_data();
    step(1'b0, 1'b1, 4'd4);
    ops[4] = 16'h0f0f;
    step(1'b0, 1'b1, 4'd4);
    ops[0] = 16'hdead; ops[3] = 16'hbeef; ops[8] = 16'h5555;
    step(1'b0, 1'b1, 4'd4);

    // Reset in the middle of a stream.
    load_plan_data();
    for (int s = 0; s < 5; s++) step(1'b0, 1'b1, 4'(s));
    step(1'b1, 1'b1, 4'd5);
    step(1'b0, 1'b1, 4'd6);
    step(1'b0, 1'b1, 4'd7);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 9; k++) ops[k] = 16'($urandom);
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_9to1.md
Name: mux_9to1

Overview:
Registered 9-to-1 word multiplexer. Selects one of nine DATA_W-bit operands (a..i) using a 4-bit select code. Presents the chosen word on a registered output with one-cycle latency. Flags out-of-range select codes (9..15) and drives a defined fill value in that case. Used as a generic operand/result steering stage in datapaths.

Parameters:
DATA_W, 16, width of each data input and of the output
FILL_VAL, 0 (DATA_W bits), value driven on y when sel is out of range

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  capture enable; when low, all outputs hold
sel  input  4  select code; 0..8 choose a..i, 9..15 out of range
a  input  DATA_W  operand 0
b  input  DATA_W  operand 1
c  input  DATA_W  operand 2
d  input  DATA_W  operand 3
e  input  DATA_W  operand 4
f  input  DATA_W  operand 5
g  input  DATA_W  operand 6
h  input  DATA_W  operand 7
i  input  DATA_W  operand 8
y  output  DATA_W  registered selected word
y_valid  output  1  high for each cycle after a capture with an in-range sel
sel_err  output  1  high for each cycle after a capture with an out-of-range sel

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: y = 0, y_valid = 0, sel_err = 0. rst has priority over en.
- Latency: 1 cycle. Values of sel and a..i sampled at edge N appear on y at edge N (visible after edge N, before edge N+1).
- Capture (rst = 0, en = 1):
  - sel 0 -> y <= a; 1 -> b; 2 -> c; 3 -> d; 4 -> e; 5 -> f; 6 -> g; 7 -> h; 8 -> i.
  - sel in 0..8: y_valid <= 1, sel_err <= 0.
  - sel in 9..15: y <= FILL_VAL, y_valid <= 0, sel_err <= 1.
- Hold (rst = 0, en = 0): y, y_valid and sel_err keep their previous values. Changes on sel or a..i have no effect.
- Selection logic is purely combinational ahead of the output register. It has no priority chain; exactly one source is chosen per code.
- Changing only a data input while sel is constant propagates at the next enabled edge. No other state is held.
- X/Z on sel or on the selected input may propagate to y. Unselected inputs never affect y.
- Back-to-back sel changes on consecutive enabled edges each produce the matching output. There is no dead cycle.
- Reset asserted mid-stream clears all outputs at that edge. The first capture after rst deasserts behaves normally.
- y_valid and sel_err are never both 1.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> y=0000, y_valid=0, sel_err=0. Release rst with en=0 -> outputs stay 0.
- Full sweep: a=1234, b=5678, c=9101, d=1213, e=9873, f=fefd, g=1ddd, h=bcde, i=efdd, en=1; sel=0..8 on consecutive cycles -> y = 1234, 5678, 9101, 1213, 9873, fefd, 1ddd, bcde, efdd, each one cycle after its sel, with y_valid=1, sel_err=0.
- Out-of-range: same data; sel=9..15 on consecutive cycles -> y=0000, sel_err=1, y_valid=0 for each. Then sel=3 -> y=1213, y_valid=1, sel_err=0.
- Hold: sel=1 captured (y=5678), then en=0 with sel=7 and b changed to aaaa -> y stays 5678 for 3 cycles. Set en=1 -> y=bcde.
- Data tracking: sel=4 constant, en=1; e changes 9873 -> 0f0f -> y follows one cycle later. Changing other inputs leaves y unchanged.
- Reset mid-operation: streaming sel=0..8; assert rst at sel=5 -> y=0000, flags 0 on that edge. Deassert with sel=6 -> y=1ddd next cycle.
